// File: rtl/cnt_pkg.sv
// Shared definitions for the count unit: state encoding, default sizes and
// the prescaler width rule.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

  // Prescaler counter width: enough bits to hold PRESCALE-1, never zero.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and pulses tick on every PRESCALE-th one.
// clear (or reset) returns the counter to zero so each run starts aligned.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  // With PRESCALE=1 the counter sits at 0 == LAST, so every enabled cycle ticks.
  assign tick = enable && (pre == LAST);

  // Advance while enabled, wrap to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre <= '0;
    end else if (enable) begin
      if (tick) pre <= '0;
      else      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/count_unit.sv
// Loadable down-counter stepped by a prescaled tick.
//
// Handshake: start_cnt is a single-cycle request with no ready signal. It is
// accepted only in IDLE; a request seen in RUN or DONE is dropped without
// affecting the operation and is reported on overrun for that same cycle.
module count_unit
  import cnt_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_cnt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             cnt_done,
  output logic             overrun,
  output state_t           dbg_state
);

  state_t state;
  logic   in_run;

  assign in_run = (state == RUN);

  // Prescaler only runs in RUN and is held at zero everywhere else, so a
  // freshly loaded count always sees a full PRESCALE cycles before its first step.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_run),
    .enable (in_run),
    .tick   (tick)
  );

  // Status decoded straight from the state register.
  assign busy      = in_run;
  assign cnt_done  = (state == DONE);
  assign overrun   = start_cnt && (state != IDLE);
  assign dbg_state = state;

  // Main control: load on start, decrement on tick, one DONE cycle at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_cnt) begin
            if (data_in != '0) begin
              state <= RUN;
              count <= data_in;
            end else begin
              state <= DONE;
              count <= '0;
            end
          end
        end
        RUN: begin
          // count is at least 1 throughout RUN, so this never wraps.
          if (tick) begin
            count <= count - WIDTH'(1);
            if (count == WIDTH'(1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
